mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Multi-cycle load/store bus stage that sits directly downstream of the ALU.
- Takes the ALU's effective address, byte offset and lane-positioned store data, and runs one Avalon-style memory transaction with waitrequest handshaking.
- Captures the read word and returns it to the ALU's ram_readdata_i for byte, half and word extraction.
- Flags misaligned accesses and bus stalls that exceed a cycle limit.

Parameters:
- TIMEOUT_CYCLES, 1024: maximum consecutive waitrequest-high cycles before the transaction is aborted; 0 disables the timeout.
- CNT_W, 16: width of the stall counter; must satisfy TIMEOUT_CYCLES < 2^CNT_W.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_ni  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle request strobe; sampled only in IDLE.
- is_store_i  in  1  1 = store, 0 = load.
- size_i  in  mem_size_t  access size: MEM_BYTE, MEM_HALF or MEM_WORD.
- address_i  in  32  effective address from the ALU; low 2 bits are ignored.
- byte_offset_i  in  2  byte offset within the word; offset 0 = bits 31:24.
- store_data_i  in  32  store data, already shifted into its lane by the ALU.
- avm_address_o  out  32  word-aligned bus address.
- avm_read_o  out  1  read strobe.
- avm_write_o  out  1  write strobe.
- avm_writedata_o  out  32  write data.
- avm_byteenable_o  out  4  byte-lane enables; bit 3 = bits 31:24.
- avm_waitrequest_i  in  1  slave stall.
- avm_readdata_i  in  32  read data; valid the cycle after the read is accepted.
- readdata_o  out  32  captured read word; feeds the ALU's ram_readdata_i.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle completion pulse.
- error_o  out  1  qualifies done_o; high on misalignment or timeout.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE.
  - All strobes, done_o, error_o and busy_o = 0.
  - avm_address_o, avm_writedata_o and readdata_o = 0; avm_byteenable_o = 4'b0000.
  - Stall counter = 0.
  - Reset mid-transaction drops the strobe asynchronously; no done_o is produced.
- All outputs are registered.
- FSM states: IDLE, REQ, RDATA, DONE.
- IDLE:
  - With start_i = 1, latch the address (low 2 bits forced to 00), writedata, byteenable and direction.
  - If the access is misaligned, go to DONE with error flagged; no bus strobe is issued.
  - Otherwise go to REQ.
  - start_i is ignored in every other state.
- Misaligned accesses:
  - MEM_HALF with byte_offset_i = 1 or 3.
  - MEM_WORD with byte_offset_i != 0.
- Byteenable:
  - Byte: offset 0→1000, 1→0100, 2→0010, 3→0001.
  - Half: offset 0→1100, 2→0011.
  - Word: 1111.
  - Loads and stores use the same mapping.
- REQ:
  - The selected strobe (read or write) stays high and all bus outputs stay stable while avm_waitrequest_i = 1.
  - Acceptance is the cycle in which the strobe is high and waitrequest = 0.
  - On an accepted write: drop the strobe and go to DONE.
  - On an accepted read: drop the strobe and go to RDATA.
  - The stall counter increments on each waitrequest-high cycle.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES: drop the strobe, go to DONE with error; readdata_o is left unchanged.
- RDATA: readdata_o <= avm_readdata_i, then go to DONE.
- DONE:
  - done_o = 1 for exactly one cycle; error_o is valid with it.
  - Return to IDLE and clear the counter.
- Latency with zero wait states, start in cycle T:
  - Strobe high in T+1.
  - Write: done_o in T+2.
  - Read: data sampled at the end of T+2; done_o in T+3.
  - Misaligned: done_o with error_o = 1 in T+1.
- readdata_o holds its value until the next successful read completes.
- start_i asserted in the DONE cycle is ignored; it is accepted the cycle after, in IDLE.

Decomposition:
- Add to the codes package:
  - mem_size_t enum: MEM_BYTE = 2'b00, MEM_HALF = 2'b01, MEM_WORD = 2'b10.
  - mem_state_t enum for the FSM states.
  - Function byteenable_for(size, offset).
- One natural sub-module: mem_stall_timer, containing the counter, clear/enable inputs and an expired output.

Test Plan:
- LW, address 0x1000_0008, waitrequest held 0, readdata 0xDEAD_BEEF in the cycle after acceptance → avm_address_o = 0x1000_0008, byteenable = 1111, done_o in T+3, readdata_o = 0xDEADBEEF, error_o = 0.
- SB, address 0x0000_0403 (offset 3), store_data 0x0000_00AB, waitrequest high for 3 cycles → write held 4 cycles, address 0x0000_0400, byteenable = 0001, writedata 0x000000AB stable throughout, done_o 1 cycle after acceptance.
- LH with offset 1 → no strobe, done_o = 1 and error_o = 1 in T+1, readdata_o unchanged.
- TIMEOUT_CYCLES = 4, LW with waitrequest stuck at 1 → read high 4 cycles, then dropped, done_o with error_o = 1, busy_o returns to 0.
- reset_ni pulled low in the middle of a stalled SW → avm_write_o falls without waiting for a clock edge; after release busy_o = 0 and no done_o is seen.
- start_i pulsed during REQ and again in the DONE cycle → both ignored; a start in the following IDLE cycle launches a new transaction.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the load/store bus stage.
// Size/state encodings plus the size+offset to byte-lane mapping.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_REQ   = 2'b01,
        ST_RDATA = 2'b10,
        ST_DONE  = 2'b11
    } mem_state_t;

    // Lane 3 (bit 3) is the most significant byte, i.e. byte offset 0.
    function automatic logic [3:0] byteenable_for(mem_size_t size, logic [1:0] offset);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            MEM_BYTE: be = 4'b1000 >> offset;
            MEM_HALF: begin
                if (offset == 2'd0)      be = 4'b1100;
                else if (offset == 2'd2) be = 4'b0011;
                else                     be = 4'b0000;
            end
            MEM_WORD: be = 4'b1111;
            default:  be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic is_misaligned(mem_size_t size, logic [1:0] offset);
        logic bad;
        case (size)
            MEM_BYTE: bad = 1'b0;
            MEM_HALF: bad = offset[0];
            MEM_WORD: bad = (offset != 2'd0);
            default:  bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_unit_stall_timer.sv
// Counts consecutive waitrequest-high cycles and flags the one that hits the limit.
// Zero latency on expired; clear has priority over enable; TIMEOUT_CYCLES = 0 never expires.
module mem_stall_timer #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic clk,
    input  logic reset_ni,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // The stall in progress is the one that brings the count up to the limit.
    assign expired = (TIMEOUT_CYCLES != 0) && enable && (count == LAST);

endmodule

// File: rtl/mem_access_unit.sv
// Runs one Avalon-style load/store per start strobe and returns the read word to the ALU.
// Zero-wait latency: write done T+2, read done T+3, misaligned T+1; holds strobe while waitrequest.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        reset_ni,
    input  logic        start_i,
    input  logic        is_store_i,
    input  mem_size_t   size_i,
    input  logic [31:0] address_i,
    input  logic [1:0]  byte_offset_i,
    input  logic [31:0] store_data_i,
    output logic [31:0] avm_address_o,
    output logic        avm_read_o,
    output logic        avm_write_o,
    output logic [31:0] avm_writedata_o,
    output logic [3:0]  avm_byteenable_o,
    input  logic        avm_waitrequest_i,
    input  logic [31:0] avm_readdata_i,
    output logic [31:0] readdata_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o
);

    mem_state_t  state_q, state_d;
    logic        store_q, store_d;
    logic        read_d, write_d, done_d, error_d, busy_d;
    logic [31:0] addr_d, wdata_d, rdata_d;
    logic [3:0]  be_d;
    logic        stall_expired;

    // The ALU supplies the lane position separately; the address low bits carry no information.
    logic unused_addr_bits;
    assign unused_addr_bits = ^address_i[1:0];

    mem_stall_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_stall_timer (
        .clk      (clk),
        .reset_ni (reset_ni),
        .clear    (state_q != ST_REQ),
        .enable   ((state_q == ST_REQ) && avm_waitrequest_i),
        .expired  (stall_expired)
    );

    always_comb begin
        state_d = state_q;
        store_d = store_q;
        read_d  = avm_read_o;
        write_d = avm_write_o;
        addr_d  = avm_address_o;
        wdata_d = avm_writedata_o;
        be_d    = avm_byteenable_o;
        rdata_d = readdata_o;
        done_d  = 1'b0;
        error_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    addr_d  = {address_i[31:2], 2'b00};
                    wdata_d = store_data_i;
                    be_d    = byteenable_for(size_i, byte_offset_i);
                    store_d = is_store_i;
                    if (is_misaligned(size_i, byte_offset_i)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                        read_d  = !is_store_i;
                        write_d = is_store_i;
                    end
                end
            end
            ST_REQ: begin
                if (!avm_waitrequest_i) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = store_q ? ST_DONE : ST_RDATA;
                    done_d  = store_q;
                end else if (stall_expired) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    error_d = 1'b1;
                end
            end
            ST_RDATA: begin
                rdata_d = avm_readdata_i;
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q          <= ST_IDLE;
            store_q          <= 1'b0;
            avm_read_o       <= 1'b0;
            avm_write_o      <= 1'b0;
            avm_address_o    <= '0;
            avm_writedata_o  <= '0;
            avm_byteenable_o <= 4'b0000;
            readdata_o       <= '0;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            error_o          <= 1'b0;
        end else begin
            state_q          <= state_d;
            store_q          <= store_d;
            avm_read_o       <= read_d;
            avm_write_o      <= write_d;
            avm_address_o    <= addr_d;
            avm_writedata_o  <= wdata_d;
            avm_byteenable_o <= be_d;
            readdata_o       <= rdata_d;
            busy_o           <= busy_d;
            done_o           <= done_d;
            error_o          <= error_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a short stall limit.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk;
    logic        reset_ni;
    logic        start_i;
    logic        is_store_i;
    mem_size_t   size_i;
    logic [31:0] address_i;
    logic [1:0]  byte_offset_i;
    logic [31:0] store_data_i;
    logic [31:0] avm_address_o;
    logic        avm_read_o;
    logic        avm_write_o;
    logic [31:0] avm_writedata_o;
    logic [3:0]  avm_byteenable_o;
    logic        avm_waitrequest_i;
    logic [31:0] avm_readdata_i;
    logic [31:0] readdata_o;
    logic        busy_o;
    logic        done_o;
    logic        error_o;

    int n_cmp = 0;
    int n_err = 0;

    mem_access_unit #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (16)
    ) dut (
        .clk               (clk),
        .reset_ni          (reset_ni),
        .start_i           (start_i),
        .is_store_i        (is_store_i),
        .size_i            (size_i),
        .address_i         (address_i),
        .byte_offset_i     (byte_offset_i),
        .store_data_i      (store_data_i),
        .avm_address_o     (avm_address_o),
        .avm_read_o        (avm_read_o),
        .avm_write_o       (avm_write_o),
        .avm_writedata_o   (avm_writedata_o),
        .avm_byteenable_o  (avm_byteenable_o),
        .avm_waitrequest_i (avm_waitrequest_i),
        .avm_readdata_i    (avm_readdata_i),
        .readdata_o        (readdata_o),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .error_o           (error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic st, input mem_size_t sz, input logic [31:0] addr,
                          input logic [1:0] off, input logic [31:0] data);
        start_i       = 1'b1;
        is_store_i    = st;
        size_i        = sz;
        address_i     = addr;
        byte_offset_i = off;
        store_data_i  = data;
    endtask

    initial begin
        reset_ni          = 1'b0;
        start_i           = 1'b0;
        is_store_i        = 1'b0;
        size_i            = MEM_WORD;
        address_i         = '0;
        byte_offset_i     = '0;
        store_data_i      = '0;
        avm_waitrequest_i = 1'b0;
        avm_readdata_i    = '0;

        step();
        step();
        chk_eq("rst_busy",  {31'd0, busy_o},      32'd0);
        chk_eq("rst_done",  {31'd0, done_o},      32'd0);
        chk_eq("rst_error", {31'd0, error_o},     32'd0);
        chk_eq("rst_read",  {31'd0, avm_read_o},  32'd0);
        chk_eq("rst_write", {31'd0, avm_write_o}, 32'd0);
        chk_eq("rst_addr",  avm_address_o,        32'd0);
        chk_eq("rst_wdata", avm_writedata_o,      32'd0);
        chk_eq("rst_be",    {28'd0, avm_byteenable_o}, 32'd0);
        chk_eq("rst_rdata", readdata_o,           32'd0);
        #2 reset_ni = 1'b1;
        step();

        // LW, zero wait states
        launch(1'b0, MEM_WORD, 32'h1000_0008, 2'd0, 32'h0);
        step();
        start_i = 1'b0;
        chk_eq("lw_read_t1", {31'd0, avm_read_o}, 32'd1);
        chk_eq("lw_addr",    avm_address_o, 32'h1000_0008);
        chk_eq("lw_be",      {28'd0, avm_byteenable_o}, 32'hF);
        chk_eq("lw_busy",    {31'd0, busy_o}, 32'd1);
        avm_readdata_i = 32'h0BAD_0BAD;
        step();
        chk_eq("lw_read_t2", {31'd0, avm_read_o}, 32'd0);
        chk_eq("lw_done_t2", {31'd0, done_o}, 32'd0);
        avm_readdata_i = 32'hDEAD_BEEF;
        step();
        avm_readdata_i = 32'h0;
        chk_eq("lw_done_t3", {31'd0, done_o}, 32'd1);
        chk_eq("lw_err",     {31'd0, error_o}, 32'd0);
        chk_eq("lw_rdata",   readdata_o, 32'hDEAD_BEEF);
        step();
        chk_eq("lw_done_t4", {31'd0, done_o}, 32'd0);
        chk_eq("lw_idle",    {31'd0, busy_o}, 32'd0);

        // SB offset 3 with three stall cycles
        avm_waitrequest_i = 1'b1;
        launch(1'b1, MEM_BYTE, 32'h0000_0403, 2'd3, 32'h0000_00AB);
        step();
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_eq($sformatf("sb_write_%0d", i), {31'd0, avm_write_o}, 32'd1);
            chk_eq($sformatf("sb_addr_%0d", i),  avm_address_o, 32'h0000_0400);
            chk_eq($sformatf("sb_be_%0d", i),    {28'd0, avm_byteenable_o}, 32'h1);
            chk_eq($sformatf("sb_wdata_%0d", i), avm_writedata_o, 32'h0000_00AB);
            chk_eq($sformatf("sb_nodone_%0d", i), {31'd0, done_o}, 32'd0);
            if (i == 3) avm_waitrequest_i = 1'b0;
            step();
        end
        chk_eq("sb_write_off", {31'd0, avm_write_o}, 32'd0);
        chk_eq("sb_done",      {31'd0, done_o}, 32'd1);
        chk_eq("sb_err",       {31'd0, error_o}, 32'd0);
        step();
        chk_eq("sb_done_off",  {31'd0, done_o}, 32'd0);

        // LH misaligned
        launch(1'b0, MEM_HALF, 32'h0000_2001, 2'd1, 32'h0);
        step();
        start_i = 1'b0;
        chk_eq("lh_done",  {31'd0, done_o}, 32'd1);
        chk_eq("lh_err",   {31'd0, error_o}, 32'd1);
        chk_eq("lh_read",  {31'd0, avm_read_o}, 32'd0);
        chk_eq("lh_write", {31'd0, avm_write_o}, 32'd0);
        chk_eq("lh_rdata", readdata_o, 32'hDEAD_BEEF);
        step();
        chk_eq("lh_idle",  {31'd0, busy_o}, 32'd0);
        chk_eq("lh_done_off", {31'd0, done_o}, 32'd0);

        // LW with waitrequest stuck high: times out after 4 cycles
        avm_waitrequest_i = 1'b1;
        launch(1'b0, MEM_WORD, 32'h0000_3000, 2'd0, 32'h0);
        step();
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_eq($sformatf("to_read_%0d", i), {31'd0, avm_read_o}, 32'd1);
            chk_eq($sformatf("to_nodone_%0d", i), {31'd0, done_o}, 32'd0);
            step();
        end
        chk_eq("to_read_off", {31'd0, avm_read_o}, 32'd0);
        chk_eq("to_done",     {31'd0, done_o}, 32'd1);
        chk_eq("to_err",      {31'd0, error_o}, 32'd1);
        chk_eq("to_rdata",    readdata_o, 32'hDEAD_BEEF);
        step();
        chk_eq("to_idle",     {31'd0, busy_o}, 32'd0);
        chk_eq("to_done_off", {31'd0, done_o}, 32'd0);

        // Reset mid stalled SW
        launch(1'b1, MEM_WORD, 32'h0000_0500, 2'd0, 32'h1234_5678);
        step();
        start_i = 1'b0;
        chk_eq("rs_write_t1", {31'd0, avm_write_o}, 32'd1);
        step();
        chk_eq("rs_write_t2", {31'd0, avm_write_o}, 32'd1);
        #2 reset_ni = 1'b0;
        #1;
        chk_eq("rs_write_async", {31'd0, avm_write_o}, 32'd0);
        chk_eq("rs_busy_async",  {31'd0, busy_o}, 32'd0);
        @(negedge clk);
        reset_ni = 1'b1;
        avm_waitrequest_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_eq($sformatf("rs_nodone_%0d", i), {31'd0, done_o}, 32'd0);
            chk_eq($sformatf("rs_idle_%0d", i),   {31'd0, busy_o}, 32'd0);
            chk_eq($sformatf("rs_nowrite_%0d", i), {31'd0, avm_write_o}, 32'd0);
        end

        // start during REQ and during DONE is ignored
        avm_waitrequest_i = 1'b1;
        launch(1'b1, MEM_WORD, 32'h0000_0700, 2'd0, 32'h0000_0011);
        step();
        launch(1'b0, MEM_WORD, 32'h0000_0600, 2'd0, 32'h0);
        chk_eq("ig_write_t1", {31'd0, avm_write_o}, 32'd1);
        step();
        start_i = 1'b0;
        chk_eq("ig_addr_req",  avm_address_o, 32'h0000_0700);
        chk_eq("ig_write_t2",  {31'd0, avm_write_o}, 32'd1);
        chk_eq("ig_wdata_req", avm_writedata_o, 32'h0000_0011);
        avm_waitrequest_i = 1'b0;
        step();
        chk_eq("ig_done", {31'd0, done_o}, 32'd1);
        launch(1'b0, MEM_WORD, 32'h0000_0800, 2'd0, 32'h0);
        step();
        chk_eq("ig_idle",      {31'd0, busy_o}, 32'd0);
        chk_eq("ig_noread",    {31'd0, avm_read_o}, 32'd0);
        chk_eq("ig_done_off",  {31'd0, done_o}, 32'd0);
        step();
        start_i = 1'b0;
        chk_eq("nx_read",  {31'd0, avm_read_o}, 32'd1);
        chk_eq("nx_addr",  avm_address_o, 32'h0000_0800);
        step();
        avm_readdata_i = 32'hCAFE_F00D;
        step();
        avm_readdata_i = 32'h0;
        chk_eq("nx_done",  {31'd0, done_o}, 32'd1);
        chk_eq("nx_err",   {31'd0, error_o}, 32'd0);
        chk_eq("nx_rdata", readdata_o, 32'hCAFE_F00D);
        step();
        chk_eq("nx_idle",  {31'd0, busy_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
